// File: rtl/hdmi_audio_sample_scheduler.sv
// hdmi_audio_sample_scheduler: paces FIFO-buffered stereo samples to the HDMI core at AUDIO_RATE
module hdmi_audio_sample_scheduler #(
  parameter int CLK_HZ        = 25175000,
  parameter int AUDIO_RATE    = 48000,
  parameter int SAMPLE_W      = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter bit UNDERRUN_MUTE = 1'b0
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [SAMPLE_W-1:0]           in_l,
  input  logic [SAMPLE_W-1:0]           in_r,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [SAMPLE_W-1:0]           audio_sample_l,
  output logic [SAMPLE_W-1:0]           audio_sample_r,
  output logic                          sample_tick,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_cnt,
  output logic                          running
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [31:0] RATE = 32'(AUDIO_RATE);
  localparam logic [31:0] CLK = 32'(CLK_HZ);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] HALF = LW'(FIFO_DEPTH / 2);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state_q, state_d;
  logic [31:0] acc_q, acc_d, nxt;
  logic tick_q, tick_d, rdy_q, rdy_d, push, pop;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [SAMPLE_W-1:0] l_q, l_d, r_q, r_d;
  logic [15:0] ucnt_q, ucnt_d;
  logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
  always_comb begin
    nxt = acc_q + RATE;
    tick_d = enable && (nxt >= CLK);
    acc_d = !enable ? '0 : tick_d ? nxt - CLK : nxt;
    push = enable && in_valid && rdy_q;
    pop = enable && (state_q == RUN) && tick_d && (lvl_q != '0);
    state_d = state_q;
    l_d = l_q;
    r_d = r_q;
    ucnt_d = ucnt_q;
    if (!enable) begin
      state_d = IDLE;
      l_d = '0;
      r_d = '0;
    end else if (state_q == IDLE) begin
      state_d = PRIME;
    end else if (state_q == PRIME) begin
      if (lvl_q >= HALF) state_d = RUN;
      if (tick_d && UNDERRUN_MUTE) {l_d, r_d} = '0;
    end else if (tick_d) begin
      {l_d, r_d} = pop ? mem[rd_q] : UNDERRUN_MUTE ? '0 : {l_q, r_q};
      if (!pop) begin
        state_d = PRIME;
        ucnt_d = ucnt_q + {15'd0, ucnt_q != 16'hFFFF};
      end
    end
    wr_d = !enable ? '0 : wr_q + AW'(push);
    rd_d = !enable ? '0 : rd_q + AW'(pop);
    lvl_d = !enable ? '0 : lvl_q + LW'(push) - LW'(pop);
    // ready reflects the post-edge level, so a pop never frees a slot in the same cycle
    rdy_d = enable && (lvl_d != FULL);
  end
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      tick_q <= 1'b0;
      rdy_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      l_q <= '0;
      r_q <= '0;
      ucnt_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      tick_q <= tick_d;
      rdy_q <= rdy_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      l_q <= l_d;
      r_q <= r_d;
      ucnt_q <= ucnt_d;
    end
  end
  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_q] <= {in_l, in_r};
  end
  assign in_ready = rdy_q;
  assign audio_sample_l = l_q;
  assign audio_sample_r = r_q;
  assign sample_tick = tick_q;
  assign fifo_level = lvl_q;
  assign underrun_cnt = ucnt_q;
  assign running = (state_q == RUN);
endmodule

// File: tb/tb_hdmi_audio_sample_scheduler.sv
// tb_hdmi_audio_sample_scheduler: three scheduler variants checked against a queue-based reference model
module tb_hdmi_audio_sample_scheduler;
  localparam int D = 8;
  localparam int MC [3] = '{100, 100, 1000};
  localparam int MA [3] = '{30, 30, 1};
  localparam bit MM [3] = '{1'b0, 1'b1, 1'b0};
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, iv = 1'b0;
  logic [15:0] il = '0, ir = '0;
  logic rdy [3], tick [3], run [3];
  logic [15:0] ol [3], orr [3], uc [3];
  logic [3:0] lvl [3];
  int vec = 0, miss = 0;
  longint n [3];
  int st [3], fl [3], eu [3];
  logic [31:0] fq [3][D];
  logic [15:0] el [3], er [3];
  bit et [3], erdy [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hdmi_audio_sample_scheduler #(
      .CLK_HZ(MC[g]), .AUDIO_RATE(MA[g]), .SAMPLE_W(16), .FIFO_DEPTH(D), .UNDERRUN_MUTE(MM[g])
    ) dut (
      .clk_pixel(clk), .reset(rst), .enable(en), .in_l(il), .in_r(ir), .in_valid(iv),
      .in_ready(rdy[g]), .audio_sample_l(ol[g]), .audio_sample_r(orr[g]), .sample_tick(tick[g]),
      .fifo_level(lvl[g]), .underrun_cnt(uc[g]), .running(run[g])
    );
  end

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_clear(input int i, input bit keep_cnt);
    n[i] = 0; st[i] = 0; fl[i] = 0; el[i] = '0; er[i] = '0; et[i] = 0; erdy[i] = 0;
    if (!keep_cnt) eu[i] = 0;
  endtask

  function automatic bit tick_at(input int i, input longint k);
    return (k * MA[i]) / MC[i] != ((k - 1) * MA[i]) / MC[i];
  endfunction

  // states: 0 idle, 1 prime, 2 run; FIFO kept as a shift list with head at index 0
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit t, pu, po;
      if (rst) model_clear(i, 1'b0);
      else if (!en) model_clear(i, 1'b1);
      else begin
        n[i]++;
        t = tick_at(i, n[i]);
        pu = iv && erdy[i];
        po = 0;
        if (st[i] == 0) st[i] = 1;
        else if (st[i] == 1) begin
          if (t && MM[i]) begin el[i] = '0; er[i] = '0; end
          if (fl[i] >= D / 2) st[i] = 2;
        end else if (t) begin
          if (fl[i] > 0) begin
            po = 1;
            {el[i], er[i]} = fq[i][0];
          end else begin
            if (eu[i] < 65535) eu[i]++;
            if (MM[i]) begin el[i] = '0; er[i] = '0; end
            st[i] = 1;
          end
        end
        if (po) begin
          for (int k = 0; k < D - 1; k++) fq[i][k] = fq[i][k+1];
          fl[i]--;
        end
        if (pu) begin
          fq[i][fl[i]] = {il, ir};
          fl[i]++;
        end
        et[i] = t;
        erdy[i] = (fl[i] != D);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("tick", i, 32'(tick[i]), 32'(et[i]));
      chk("in_ready", i, 32'(rdy[i]), 32'(erdy[i]));
      chk("out_l", i, 32'(ol[i]), 32'(el[i]));
      chk("out_r", i, 32'(orr[i]), 32'(er[i]));
      chk("level", i, 32'(lvl[i]), 32'(fl[i]));
      chk("underrun", i, 32'(uc[i]), 32'(eu[i]));
      chk("running", i, 32'(run[i]), 32'(st[i] == 2));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_l"}, i, 32'(ol[i]), 32'h0);
      chk({tag, "_r"}, i, 32'(orr[i]), 32'h0);
      chk({tag, "_lvl"}, i, 32'(lvl[i]), 32'h0);
      chk({tag, "_run"}, i, 32'(run[i]), 32'h0);
      chk({tag, "_tick"}, i, 32'(tick[i]), 32'h0);
      chk({tag, "_rdy"}, i, 32'(rdy[i]), 32'h0);
    end
  endtask

  initial begin
    int pushed, gotn, acc2, hits;
    bit hs, done, hit5;
    logic [15:0] got [4];
    for (int i = 0; i < 3; i++) model_clear(i, 1'b0);
    foreach (got[k]) got[k] = '0;
    rst = 1'b1;
    repeat (2) step();
    check_zero("reset");
    rst = 1'b0;
    en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      chk("t1_tick_cycle", 0, 32'(tick[0]), 32'(c inside {4, 7, 10, 14, 17, 20}));
    end
    pushed = 0; gotn = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      iv = pushed < 4;
      il = 16'(pushed + 1);
      ir = ~il;
      hs = iv && rdy[0];
      step();
      if (hs) pushed++;
      if (tick[0] && gotn == 4) done = 1;
      else if (tick[0] && run[0] && ol[0] != 16'h0 && gotn < 4) begin
        got[gotn] = ol[0];
        gotn++;
      end
    end
    iv = 1'b0;
    for (int k = 0; k < 4; k++) chk("t2_order", 0, 32'(got[k]), 32'(k + 1));
    chk("t3_reached", 0, 32'(done), 32'h1);
    chk("t3_hold_l", 0, 32'(ol[0]), 32'h0004);
    chk("t3_hold_r", 0, 32'(orr[0]), 32'hfffb);
    chk("t3_mute_l", 1, 32'(ol[1]), 32'h0);
    chk("t3_mute_r", 1, 32'(orr[1]), 32'h0);
    chk("t3_ucnt", 0, 32'(uc[0]), 32'h1);
    chk("t3_running", 0, 32'(run[0]), 32'h0);
    acc2 = 0;
    for (int c = 0; c < 12; c++) begin
      iv = 1'b1;
      il = 16'($urandom);
      ir = 16'($urandom);
      if (rdy[2]) acc2++;
      step();
    end
    iv = 1'b0;
    chk("t4_level", 2, 32'(lvl[2]), 32'd8);
    chk("t4_ready", 2, 32'(rdy[2]), 32'h0);
    chk("t4_accepted", 2, 32'(acc2), 32'd4);
    hits = 0;
    for (int c = 0; c < 400 && hits < 3; c++) begin
      hit5 = (fl[0] == 5) && (st[0] == 2) && tick_at(0, n[0] + 1) && erdy[0];
      iv = (fl[0] < 5) || hit5;
      il = 16'($urandom);
      ir = 16'($urandom);
      step();
      if (hit5) begin
        hits++;
        chk("t5_level", 0, 32'(lvl[0]), 32'd5);
      end
    end
    chk("t5_hits", 0, 32'(hits), 32'd3);
    iv = 1'b0;
    for (int c = 0; c < 8200; c++) step();
    chk("t4_drained", 2, 32'(lvl[2]), 32'h0);
    for (int c = 0; c < 10; c++) begin
      iv = 1'b1;
      il = 16'($urandom);
      ir = 16'($urandom);
      step();
    end
    en = 1'b0;
    step();
    check_zero("t6_flush");
    chk("t6_ucnt_kept", 0, 32'(uc[0]), 32'(eu[0]));
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      iv = 1'($urandom);
      il = 16'($urandom);
      ir = 16'($urandom);
      step();
    end
    rst = 1'b1;
    #2;
    check_zero("t6_async");
    for (int i = 0; i < 3; i++) chk("t6_async_ucnt", i, 32'(uc[i]), 32'h0);
    for (int i = 0; i < 3; i++) model_clear(i, 1'b0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      en = $urandom_range(0, 149) != 0;
      rst = $urandom_range(0, 599) == 0;
      iv = ((c / 300) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      il = 16'($urandom);
      ir = 16'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
